// File: rtl/wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_arbiter_pkg
//   Shared constants and types for the register-file write-back arbiter.
//   MAX_REQ : largest number of requesters the arbiter supports.
//   IDX_W   : width of a requester index / round-robin pointer.
//   grant_t : full-width (MAX_REQ) request/grant vector.
//   multi_hot() : true when two or more bits of a request vector are set.
// -----------------------------------------------------------------------------
package wb_arbiter_pkg;

    localparam int MAX_REQ = 4;
    localparam int IDX_W   = $clog2(MAX_REQ);

    typedef logic [MAX_REQ-1:0] grant_t;

    // Clearing the lowest set bit leaves something only if another bit was set.
    function automatic logic multi_hot(grant_t v);
        return (v & (v - grant_t'(1))) != '0;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Purely combinational round-robin selector. Searches valid_i starting at
//   ptr_i, wrapping past NREQ-1 back to 0, and returns the first hit.
//   Ports:
//     valid_i [NREQ-1:0]  request vector (already gated by the caller)
//     ptr_i   [IDX_W-1:0] requester with highest priority this cycle
//     grant_o [NREQ-1:0]  one-hot grant, all-zero when nothing is valid
//     idx_o   [IDX_W-1:0] index of the granted requester (0 when none)
//     any_o               a grant was issued
// -----------------------------------------------------------------------------
module rr_pick
    import wb_arbiter_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0]  valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    int               c;
    logic [IDX_W-1:0] sel;

    // Walk the ring from farthest to nearest so the nearest valid requester
    // is the last one written and therefore wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        c       = 0;
        sel     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            c = int'(ptr_i) + k;
            if (c >= NREQ) begin
                c = c - NREQ;
            end
            sel = IDX_W'(c);
            if (valid_i[sel]) begin
                grant_o      = '0;
                grant_o[sel] = 1'b1;
                idx_o        = sel;
                any_o        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//   Round-robin arbiter sharing the register-file write port among NREQ
//   write-back requesters. At most one write is accepted per cycle and is
//   presented to the register bank one cycle later as a registered command.
//
//   Handshake: a requester raises req_valid[i] with stable req_addr/req_data
//   and keeps them until it sees req_ready[i]; the transfer happens in the
//   cycle where valid && ready. req_ready is one-hot or zero, never depends on
//   addr/data, and is zero while hold or rst is high.
//
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     hold            register bank busy; no grant while high
//     req_valid/addr/data  packed per-requester write requests
//     req_ready       one-hot grant
//     wr_en/addr/data registered write command to the register bank
//     conflict_count  (only with WB_ARB_STATS_EN) saturating count of
//                     unheld cycles with two or more requests pending
//
//   Build option: define WB_ARB_STATS_EN to add conflict_count.
// -----------------------------------------------------------------------------
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int N    = 32,
    parameter int AW   = 4,
    parameter int NREQ = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hold,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*N-1:0]  req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               wr_en,
    output logic [AW-1:0]      wr_addr,
    output logic [N-1:0]       wr_data
`ifdef WB_ARB_STATS_EN
    ,
    output logic [15:0]        conflict_count
`endif
);

    logic [NREQ-1:0]  valid_gated;
    logic [NREQ-1:0]  grant;
    logic [IDX_W-1:0] gidx;
    logic             any_grant;

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             wr_en_q, wr_en_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [N-1:0]     wr_data_q, wr_data_d;

    // Masking the requests up front keeps the selector free of hold/rst.
    assign valid_gated = (hold || rst) ? '0 : req_valid;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .valid_i (valid_gated),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (gidx),
        .any_o   (any_grant)
    );

    assign req_ready = grant;

    always_comb begin
        ptr_d     = ptr_q;
        wr_en_d   = any_grant;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (any_grant) begin
            ptr_d     = (gidx == IDX_W'(NREQ - 1)) ? '0 : gidx + IDX_W'(1);
            wr_addr_d = req_addr[gidx*AW +: AW];
            wr_data_d = req_data[gidx*N +: N];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

`ifdef WB_ARB_STATS_EN
    logic [15:0] conflict_cnt_q, conflict_cnt_d;

    // Counts contention on the raw request vector, not on grants.
    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (!hold && multi_hot(grant_t'(req_valid)) && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt_q <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign conflict_count = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
//   Self-checking bench for wb_arbiter. A behavioural model picks the winner
//   as the valid requester at the smallest ring distance from the model
//   pointer, and tracks the expected write command and conflict counter.
//   Define WB_ARB_STATS_EN to also exercise conflict_count.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

    localparam int N    = 32;
    localparam int AW   = 4;
    localparam int NREQ = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               hold;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*N-1:0]  req_data;
    logic [NREQ-1:0]    req_ready;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [N-1:0]       wr_data;
`ifdef WB_ARB_STATS_EN
    logic [15:0]        conflict_count;
`endif

    wb_arbiter #(
        .N    (N),
        .AW   (AW),
        .NREQ (NREQ)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
`ifdef WB_ARB_STATS_EN
        ,
        .conflict_count (conflict_count)
`endif
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;

    int             m_ptr;
    logic           m_wr_en;
    logic [AW-1:0]  m_wr_addr;
    logic [N-1:0]   m_wr_data;
    int             m_cnt;
    int             last_g;

    logic [AW+N-1:0] exp_q[$];   // pending writes in grant order

    logic [NREQ-1:0] obs_ready;
    logic            obs_wr_en;
    logic [AW-1:0]   obs_wr_addr;
    logic [N-1:0]    obs_wr_data;
    logic [15:0]     obs_cnt;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Winner = valid requester at the smallest ring distance from p.
    function automatic int exp_grant(logic [NREQ-1:0] v, int p, logic h, logic r);
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = NREQ;
        if (h || r) return -1;
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) begin
                d = (i - p + NREQ) % NREQ;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    function automatic logic [NREQ-1:0] onehot(int g);
        logic [NREQ-1:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic int popcount(logic [NREQ-1:0] v);
        int s;
        s = 0;
        for (int i = 0; i < NREQ; i++) s += int'(v[i]);
        return s;
    endfunction

    // One clock: check outputs at negedge, advance model, return #1 after posedge.
    task automatic cycle();
        int g;
        logic [AW+N-1:0] w;
        @(negedge clk);
        g = exp_grant(req_valid, m_ptr, hold, rst);
        obs_ready   = req_ready;
        obs_wr_en   = wr_en;
        obs_wr_addr = wr_addr;
        obs_wr_data = wr_data;
        check_eq("req_ready", req_ready, onehot(g));
        check_eq("wr_en", wr_en, m_wr_en);
        if (m_wr_en && exp_q.size() > 0) begin
            w = exp_q.pop_front();
            check_eq("wr_addr_q", wr_addr, w[AW+N-1:N]);
            check_eq("wr_data_q", wr_data, w[N-1:0]);
        end else begin
            check_eq("wr_addr", wr_addr, m_wr_addr);
            check_eq("wr_data", wr_data, m_wr_data);
        end
`ifdef WB_ARB_STATS_EN
        obs_cnt = conflict_count;
        check_eq("conflict_count", conflict_count, m_cnt);
`endif
        // model advance for this edge
        if (rst) begin
            m_ptr = 0; m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0; m_cnt = 0;
            exp_q.delete();
        end else begin
            if (!hold && popcount(req_valid) >= 2 && m_cnt < 16'hFFFF) m_cnt++;
            if (g >= 0) begin
                m_ptr     = (g + 1) % NREQ;
                m_wr_en   = 1'b1;
                m_wr_addr = req_addr[g*AW +: AW];
                m_wr_data = req_data[g*N +: N];
                exp_q.push_back({m_wr_addr, m_wr_data});
            end else begin
                m_wr_en = 1'b0;
            end
        end
        last_g = g;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [N-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*N +: N]   = d;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; hold = 1'b0; req_valid = '1;
        req_addr = '0; req_data = '0;
        for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 8), N'(32'hA000_0000 + i));
        m_ptr = 0; m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0; m_cnt = 0; last_g = -1;
        @(posedge clk);
        #1;

        // reset held two cycles with all requests valid
        for (int k = 0; k < 2; k++) begin
            cycle();
            check_eq("rst_ready", obs_ready, 0);
        end
        rst = 1'b0; req_valid = '0;
        cycle();
        check_eq("rst_wr_en", obs_wr_en, 0);
        check_eq("rst_wr_addr", obs_wr_addr, 0);
        check_eq("rst_wr_data", obs_wr_data, 0);

        // single requester
        req_valid = 3'b010;
        set_req(1, 4'h5, 32'hE1A020A2);
        cycle();
        check_eq("single_ready", obs_ready, 3'b010);
        req_valid = '0;
        cycle();
        check_eq("single_wr_en", obs_wr_en, 1);
        check_eq("single_wr_addr", obs_wr_addr, 4'h5);
        check_eq("single_wr_data", obs_wr_data, 32'hE1A020A2);

        // rotation from ptr=0
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) set_req(i, AW'(3 * i + 1), N'(32'h0BAD_0000 + i));
        for (int k = 0; k < 6; k++) begin
            cycle();
            check_eq("rot_grant", obs_ready, onehot(k % NREQ));
            if (k > 0) check_eq("rot_wr_en", obs_wr_en, 1);
        end
        req_valid = '0;
        cycle();
        check_eq("rot_last_wr_en", obs_wr_en, 1);
        check_eq("rot_last_addr", obs_wr_addr, 4'h7);
        cycle();
        check_eq("rot_idle_wr_en", obs_wr_en, 0);

        // hold right after a grant
        req_valid = '1;
        cycle();
        check_eq("pre_hold_grant", obs_ready, 3'b001);
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check_eq("hold_ready", obs_ready, 0);
            check_eq("hold_wr_en", obs_wr_en, (k == 0) ? 1 : 0);
        end
        hold = 1'b0;
        cycle();
        check_eq("post_hold_grant", obs_ready, 3'b010);
        check_eq("post_hold_wr_en", obs_wr_en, 0);

        // reset mid-burst
        req_valid = 3'b001;
        cycle();
        check_eq("mid_pre_grant", obs_ready, 3'b001);
        req_valid = 3'b100;
        rst = 1'b1;
        cycle();
        check_eq("mid_rst_ready", obs_ready, 0);
        rst = 1'b0;
        req_valid = 3'b111;
        cycle();
        check_eq("mid_after_wr_en", obs_wr_en, 0);
        check_eq("mid_after_grant", obs_ready, 3'b001);
        req_valid = '0;
        cycle();

        // randomized traffic obeying the hold-until-ready rule
        for (int k = 0; k < 500; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || last_g == i) begin
                    req_valid[i] = ($urandom_range(0, 99) < 65);
                    set_req(i, AW'($urandom_range(0, 15)), N'($urandom()));
                end
            end
            hold = ($urandom_range(0, 99) < 15);
            rst  = ($urandom_range(0, 99) < 3);
            cycle();
        end
        hold = 1'b0;
        rst  = 1'b0;

`ifdef WB_ARB_STATS_EN
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        req_valid = 3'b011;
        for (int k = 0; k < 5; k++) cycle();
        req_valid = 3'b001;
        for (int k = 0; k < 3; k++) cycle();
        req_valid = '0;
        cycle();
        check_eq("stats_count5", obs_cnt, 16'd5);
        force dut.conflict_cnt_q = 16'hFFFE;
        #1;
        release dut.conflict_cnt_q;
        m_cnt = 16'hFFFE;
        req_valid = 3'b011;
        for (int k = 0; k < 3; k++) cycle();
        req_valid = '0;
        cycle();
        check_eq("stats_saturate", obs_cnt, 16'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Round-robin arbiter that shares the processor's single register-file write port among up to four write-back requesters, such as the ALU result, the load result and the PC-link write. It accepts at most one write per cycle through a valid/ready handshake. It drives a registered write command (enable, address, data) into the register bank, and a stall input can freeze granting.

## Interface
- N, 32: data width of every write.
- AW, 4: register address width (16 registers).
- NREQ, 3: number of requesters (2..4).
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- hold  input  1  register bank not accepting writes; no grant while high.
- req_valid  input  NREQ  per-requester write request.
- req_addr  input  NREQ×AW  packed; slice i is the destination address of requester i.
- req_data  input  NREQ×N  packed; slice i is the write data of requester i.
- req_ready  output  NREQ  one-hot grant; transfer when valid && ready.
- wr_en  output  1  registered write enable to the register bank.
- wr_addr  output  AW  registered write address.
- wr_data  output  N  registered write data.
- conflict_count  output  16  only with WB_ARB_STATS_EN (see Configuration).

## Operation
- State: round-robin pointer ptr (0..NREQ-1) and output registers.
- Grant selection is combinational. With hold=0 and rst=0, grant the first i with req_valid[i]=1, searching from ptr upward and wrapping past NREQ-1 to 0.
- req_ready is one-hot or all-zero. It is all-zero when hold=1, rst=1, or no request is valid.
- req_ready never depends on req_addr or req_data. It may depend combinationally on req_valid.
- Requesters must hold valid, addr and data stable until they see ready. A valid request may not be withdrawn before it is granted.
- On a transfer from requester g, the next edge does two things:
  - ptr <= (g+1) mod NREQ.
  - wr_en <= 1, wr_addr <= req_addr[g], wr_data <= req_data[g].
- With no transfer: wr_en <= 0, and wr_addr and wr_data hold their previous values. ptr is unchanged.
- Back-to-back grants are allowed, giving one write per cycle. A single requester that stays valid is granted every cycle.
- Two requesters targeting the same address in consecutive grants: the writes reach the bank in grant order, so the later grant wins. The arbiter does no merging.
- Reset values: ptr=0, wr_en=0, wr_addr=0, wr_data=0, conflict_count=0.

## Timing
- Grant-to-write latency is exactly 1 cycle: wr_en is high in the cycle after the cycle in which valid && ready.
- hold is sampled combinationally. Asserting hold in cycle t gives req_ready=0 in cycle t, and wr_en=0 in cycle t+1 unless a grant happened in t-1.
- Reset mid-operation: in a cycle with rst=1, req_ready=0. At the next edge every register returns to its reset value, and no write issues for requests pending during reset.
- After rst falls, the first grant is possible in the same cycle, searching from ptr=0.
- Fairness: with all NREQ requesters continuously valid, grants rotate 0,1,..,NREQ-1,0. Each requester waits at most NREQ-1 cycles.

## Configuration
- WB_ARB_STATS_EN defined:
  - Adds the conflict_count output.
  - conflict_count increments on every edge where hold=0 and two or more req_valid bits are high.
  - It saturates at 16'hFFFF and clears on rst.
- WB_ARB_STATS_EN undefined: the port and its counter logic do not exist.

## Structure
- Package wb_arbiter_pkg holds:
  - MAX_REQ=4.
  - The index-width constant.
  - A typedef for the grant vector.
- One combinational sub-module rr_pick (inputs valid vector and ptr; outputs one-hot grant and grant index), instantiated once.
- The output stage is plain flops with a synchronous reset.

## Test plan
- Reset: hold rst=1 for 2 cycles with all requests valid → req_ready=0 in both cycles, and wr_en=0, wr_addr=0, wr_data=0 after release.
- Single requester: req1 valid, addr 4'h5, data 32'hE1A020A2 → req_ready=3'b010 in the same cycle. Next cycle wr_en=1, wr_addr=5, wr_data=32'hE1A020A2.
- Rotation: all three valid for 6 cycles from ptr=0 → grants 0,1,2,0,1,2, and wr_en high for 6 consecutive cycles starting one cycle later.
- Hold: all valid and hold=1 for 3 cycles → req_ready=0 in those cycles. wr_en=0 one cycle after the first hold cycle, continuing for the rest of the hold. The first grant after hold falls is at the current ptr.
- Reset mid-burst: rst=1 while req2 is granted → the next edge has wr_en=0 and ptr=0. After release, req0 is granted first if valid.
- With WB_ARB_STATS_EN: two requesters valid for 5 cycles, then one for 3 → conflict_count=5. Forcing 16'hFFFE and then 3 conflict cycles → conflict_count holds at 16'hFFFF.
